// File: rtl/noc_mesh_router.sv
// 5-port (L,N,S,E,W) XY mesh router: per-input FIFOs, credit-based outputs, per-output round-robin.
// Optional NOC_ROUTER_DROP_CNT_EN adds a saturating drop_cnt[7:0] output.
module noc_mesh_router #(
  parameter logic [3:0]  XCOORD  = 4'd0,
  parameter logic [3:0]  YCOORD  = 4'd0,
  parameter int unsigned DATA_W  = 16,
  parameter int unsigned DEPTH   = 4,
  parameter logic [4:0]  PORT_EN = 5'b11111
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [5*DATA_W-1:0] in_data,
  input  logic [4:0]          in_valid,
  output logic [4:0]          in_credit,
  output logic [5*DATA_W-1:0] out_data,
  output logic [4:0]          out_valid,
  input  logic [4:0]          out_credit
`ifdef NOC_ROUTER_DROP_CNT_EN
  ,
  output logic [7:0]          drop_cnt
`endif
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [DATA_W-1:0] mem_q [5][DEPTH];
  logic [AW-1:0]     rd_q [5];
  logic [AW-1:0]     wr_q [5];
  logic [CW-1:0]     cnt_q [5];
  logic [CW-1:0]     crd_q [5];
  logic [2:0]        rr_q [5];
  logic [DATA_W-1:0] out_data_q [5];
  logic [4:0]        out_valid_q;
  logic [4:0]        in_credit_q;

  logic [DATA_W-1:0] head [5];
  logic [2:0]        dst [5];
  logic [2:0]        win [5];
  logic [4:0]        has, push, pop, grant;
  int unsigned       idx;

  // Port indices: L=0, N=1, S=2, E=3, W=4.
  function automatic logic [2:0] route(input logic [7:0] hdr);
    if (hdr[7:4] > XCOORD)      return 3'd3;
    else if (hdr[7:4] < XCOORD) return 3'd4;
    else if (hdr[3:0] > YCOORD) return 3'd1;
    else if (hdr[3:0] < YCOORD) return 3'd2;
    else                        return 3'd0;
  endfunction

  always_comb begin
    has   = '0;
    push  = '0;
    pop   = '0;
    grant = '0;
    idx   = 0;
    for (int unsigned i = 0; i < 5; i++) begin
      head[i] = mem_q[i][rd_q[i]];
      dst[i]  = route(head[i][7:0]);
      has[i]  = PORT_EN[i] && (cnt_q[i] != '0);
      win[i]  = '0;
    end
    // Search for each output starts at rr_q, the input after the last one granted.
    for (int unsigned o = 0; o < 5; o++) begin
      if (PORT_EN[o] && (crd_q[o] != '0)) begin
        for (int unsigned k = 0; k < 5; k++) begin
          idx = (32'(rr_q[o]) + k) % 5;
          if (!grant[o] && has[3'(idx)] && (dst[3'(idx)] == 3'(o))) begin
            grant[o] = 1'b1;
            win[o]   = 3'(idx);
          end
        end
      end
    end
    for (int unsigned i = 0; i < 5; i++)
      if (has[i] && !PORT_EN[dst[i]]) pop[i] = 1'b1;
    for (int unsigned o = 0; o < 5; o++)
      if (grant[o]) pop[win[o]] = 1'b1;
    // A full FIFO still accepts a push when its head leaves in the same cycle.
    for (int unsigned i = 0; i < 5; i++)
      push[i] = PORT_EN[i] && in_valid[i] && ((cnt_q[i] != CW'(DEPTH)) || pop[i]);
  end

  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < 5; i++)
      if (push[i]) mem_q[i][wr_q[i]] <= in_data[i*DATA_W +: DATA_W];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < 5; i++) begin
        rd_q[i]       <= '0;
        wr_q[i]       <= '0;
        cnt_q[i]      <= '0;
        crd_q[i]      <= CW'(DEPTH);
        rr_q[i]       <= '0;
        out_data_q[i] <= '0;
      end
      out_valid_q <= '0;
      in_credit_q <= '0;
    end else begin
      for (int unsigned i = 0; i < 5; i++) begin
        if (push[i]) wr_q[i] <= wr_q[i] + AW'(1);
        if (pop[i])  rd_q[i] <= rd_q[i] + AW'(1);
        case ({push[i], pop[i]})
          2'b10:   cnt_q[i] <= cnt_q[i] + CW'(1);
          2'b01:   cnt_q[i] <= cnt_q[i] - CW'(1);
          default: cnt_q[i] <= cnt_q[i];
        endcase
        if (out_credit[i] && !grant[i] && (crd_q[i] != CW'(DEPTH)))
          crd_q[i] <= crd_q[i] + CW'(1);
        else if (grant[i] && !out_credit[i])
          crd_q[i] <= crd_q[i] - CW'(1);
        if (grant[i]) begin
          rr_q[i]       <= (win[i] == 3'd4) ? 3'd0 : win[i] + 3'd1;
          out_data_q[i] <= head[win[i]];
        end
      end
      out_valid_q <= grant;
      in_credit_q <= pop & PORT_EN;
    end
  end

  always_comb begin
    out_data  = '0;
    out_valid = '0;
    in_credit = '0;
    for (int unsigned i = 0; i < 5; i++) begin
      if (PORT_EN[i]) begin
        out_data[i*DATA_W +: DATA_W] = out_data_q[i];
        out_valid[i]                 = out_valid_q[i];
        in_credit[i]                 = in_credit_q[i];
      end
    end
  end

`ifdef NOC_ROUTER_DROP_CNT_EN
  logic [7:0] drop_cnt_q;
  logic [3:0] ndrop;
  logic [8:0] dsum;

  // Up to ten drops per cycle: one overflow and one misroute per input.
  always_comb begin
    ndrop = '0;
    for (int unsigned i = 0; i < 5; i++) begin
      if (PORT_EN[i] && in_valid[i] && !push[i]) ndrop = ndrop + 4'd1;
      if (pop[i] && !PORT_EN[dst[i]])            ndrop = ndrop + 4'd1;
    end
    dsum = {1'b0, drop_cnt_q} + 9'(ndrop);
  end

  always_ff @(posedge clk) begin
    if (rst) drop_cnt_q <= '0;
    else     drop_cnt_q <= dsum[8] ? 8'hFF : dsum[7:0];
  end

  assign drop_cnt = drop_cnt_q;
`endif

endmodule

// File: tb/tb_noc_mesh_router.sv
// Directed bench for noc_mesh_router at (1,1): full-port router plus a PORT_EN=5'b10011 router.
module tb_noc_mesh_router;
  logic        clk = 1'b0;
  logic        rst;
  logic [79:0] in_data, out_data, d_in_data, d_out_data;
  logic [4:0]  in_valid, in_credit, out_valid, out_credit;
  logic [4:0]  d_in_valid, d_in_credit, d_out_valid, d_out_credit;
  logic [7:0]  drop_cnt, d_drop_cnt;
  int          total = 0;
  int          bad = 0;
  int          c, ic;
  logic [15:0] last;

  always #5 clk = ~clk;

  noc_mesh_router #(.XCOORD(4'd1), .YCOORD(4'd1), .DATA_W(16), .DEPTH(4), .PORT_EN(5'b11111)) u_dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_credit(in_credit),
    .out_data(out_data), .out_valid(out_valid), .out_credit(out_credit)
`ifdef NOC_ROUTER_DROP_CNT_EN
    , .drop_cnt(drop_cnt)
`endif
  );

  noc_mesh_router #(.XCOORD(4'd1), .YCOORD(4'd1), .DATA_W(16), .DEPTH(4), .PORT_EN(5'b10011)) u_dis (
    .clk(clk), .rst(rst), .in_data(d_in_data), .in_valid(d_in_valid), .in_credit(d_in_credit),
    .out_data(d_out_data), .out_valid(d_out_valid), .out_credit(d_out_credit)
`ifdef NOC_ROUTER_DROP_CNT_EN
    , .drop_cnt(d_drop_cnt)
`endif
  );

`ifndef NOC_ROUTER_DROP_CNT_EN
  assign drop_cnt   = '0;
  assign d_drop_cnt = '0;
`endif

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [79:0] obs, input logic [79:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic put(input int p, input logic [15:0] d);
    in_data[p*16 +: 16] = d;
    in_valid[p] = 1'b1;
  endtask

  // Advance n cycles, counting out_valid[o] and in_credit[0] pulses and keeping the last flit on o.
  task automatic run(input int n, input int o);
    for (int s = 0; s < n; s++) begin
      step();
      if (out_valid[o]) begin c++; last = out_data[o*16 +: 16]; end
      if (in_credit[0]) ic++;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] rv_d [4];
    int          rv_p [4];
    rv_d = '{16'h5501, 16'h7712, 16'h8810, 16'h9911};
    rv_p = '{4, 1, 2, 0};

    rst = 1'b1; in_data = '0; in_valid = '0; out_credit = '1;
    d_in_data = '0; d_in_valid = '0; d_out_credit = '1;
    step(); step();
    chk("rst_out_valid", 80'(out_valid), 80'(0));
    chk("rst_in_credit", 80'(in_credit), 80'(0));
    chk("rst_out_data", out_data, 80'(0));
    rst = 1'b0;

    // L -> E, two-cycle latency and single credit pulse
    put(0, 16'hAB21); step(); in_valid = '0;
    chk("lat_early", 80'(out_valid), 80'(0));
    step();
    chk("lat_out_valid", 80'(out_valid), 80'(5'b01000));
    chk("lat_out_data", 80'(out_data[48 +: 16]), 80'(16'hAB21));
    chk("lat_in_credit", 80'(in_credit), 80'(5'b00001));
    step();
    chk("lat_valid_drop", 80'(out_valid), 80'(0));
    chk("lat_credit_once", 80'(in_credit), 80'(0));
    chk("lat_data_hold", 80'(out_data[48 +: 16]), 80'(16'hAB21));

    // XY routing of each remaining direction
    for (int v = 0; v < 4; v++) begin
      put(0, rv_d[v]); step(); in_valid = '0; step();
      chk("route_valid", 80'(out_valid), 80'(5'b1 << rv_p[v]));
      chk("route_data", 80'(out_data[rv_p[v]*16 +: 16]), 80'(rv_d[v]));
      step();
    end

    // N and W contend for L; second pair arrives while W's first flit is still waiting
    put(1, 16'hB111); put(4, 16'hC411); step();
    put(1, 16'hB211); put(4, 16'hC211); step(); in_valid = '0;
    chk("rr1_data", 80'(out_data[15:0]), 80'(16'hB111));
    chk("rr1_credit", 80'(in_credit), 80'(5'b00010));
    step();
    chk("rr2_data", 80'(out_data[15:0]), 80'(16'hC411));
    chk("rr2_credit", 80'(in_credit), 80'(5'b10000));
    step();
    chk("rr3_data", 80'(out_data[15:0]), 80'(16'hB211));
    step();
    chk("rr4_data", 80'(out_data[15:0]), 80'(16'hC211));
    chk("rr4_valid", 80'(out_valid), 80'(5'b00001));
    step();

    // Credit exhaustion on E: DEPTH+1 flits, only DEPTH leave
    out_credit = 5'b10111; c = 0; ic = 0;
    for (int k = 0; k < 5; k++) begin
      put(0, 16'h1020 + 16'(k)); run(1, 3);
    end
    in_valid = '0; run(6, 3);
    chk("credit_stall_cnt", 80'(c), 80'(4));
    chk("credit_stall_last", 80'(last), 80'(16'h1023));
    c = 0;
    out_credit[3] = 1'b1; run(1, 3); out_credit[3] = 1'b0; run(6, 3);
    chk("credit_one_cnt", 80'(c), 80'(1));
    chk("credit_one_data", 80'(last), 80'(16'h1024));

    // E credits are now zero: five writes into L's FIFO keep four, drop one
    c = 0; ic = 0;
    for (int k = 0; k < 5; k++) begin
      put(0, 16'h3020 + 16'(k)); run(1, 3);
    end
    in_valid = '0;
    chk("full_no_send", 80'(c), 80'(0));
`ifdef NOC_ROUTER_DROP_CNT_EN
    chk("full_drop_cnt", 80'(drop_cnt), 80'(1));
`endif
    out_credit = '1; run(12, 3);
    chk("full_kept_cnt", 80'(c), 80'(4));
    chk("full_kept_last", 80'(last), 80'(16'h3023));
    chk("full_credit_cnt", 80'(ic), 80'(4));

    // Reset with three flits stranded in L
    out_credit = 5'b10111; c = 0;
    for (int k = 0; k < 7; k++) begin
      put(0, 16'h4020 + 16'(k)); run(1, 3);
    end
    in_valid = '0;
    chk("pre_rst_sent", 80'(c), 80'(4));
    run(1, 3);
    rst = 1'b1; step(); rst = 1'b0;
    chk("mid_rst_valid", 80'(out_valid), 80'(0));
    chk("mid_rst_credit", 80'(in_credit), 80'(0));
    chk("mid_rst_data", out_data, 80'(0));
`ifdef NOC_ROUTER_DROP_CNT_EN
    chk("mid_rst_drop_cnt", 80'(drop_cnt), 80'(0));
`endif
    out_credit = '1; c = 0; ic = 0;
    run(8, 3);
    chk("no_stale_flit", 80'(c), 80'(0));
    chk("no_stale_credit", 80'(ic), 80'(0));
    out_credit = 5'b10111; c = 0;
    for (int k = 0; k < 5; k++) begin
      put(0, 16'h5020 + 16'(k)); run(1, 3);
    end
    in_valid = '0; run(6, 3);
    chk("rst_credits_depth", 80'(c), 80'(4));
    out_credit = '1;

    // Disabled S and E on u_dis
    d_in_data[15:0] = 16'h0021; d_in_valid = 5'b00001; step(); d_in_valid = '0; step();
    chk("dis_drop_valid", 80'(d_out_valid), 80'(0));
    chk("dis_drop_credit", 80'(d_in_credit), 80'(5'b00001));
`ifdef NOC_ROUTER_DROP_CNT_EN
    chk("dis_drop_cnt", 80'(d_drop_cnt), 80'(1));
`endif
    step();
    d_in_data[47:32] = 16'h0011; d_in_valid = 5'b00100; step(); d_in_valid = '0; step();
    chk("dis_in_ignored_valid", 80'(d_out_valid), 80'(0));
    chk("dis_in_ignored_credit", 80'(d_in_credit), 80'(0));
    chk("dis_out_data_zero", d_out_data, 80'(0));
    step();
    d_in_data[15:0] = 16'h7711; d_in_valid = 5'b00001; step(); d_in_valid = '0; step();
    chk("dis_local_valid", 80'(d_out_valid), 80'(5'b00001));
    chk("dis_local_data", 80'(d_out_data[15:0]), 80'(16'h7711));
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
